// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage and IF/ID register; FETCH_PERF_CNT_EN adds fetch/bubble counters
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'hE000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_pc,
    output logic        imem_rd_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] curr_pc_fd,
    output logic [15:0] curr_instr_fd,
    output logic        fd_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        BUF   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] buf_instr;
    logic [15:0] load_instr;
    logic [15:0] redirect_pc;
    logic        drop;
    logic        do_load;
    logic        load_hlt;

    // Instructions are halfword aligned, so the low bit of a redirect is forced to zero.
    assign imem_addr   = pc;
    assign redirect_pc = branch_pc & 16'hFFFE;
    assign load_instr  = (state == BUF) ? buf_instr : imem_data;
    assign load_hlt    = (load_instr[15:12] == HLT_OPCODE);

    // Request: one per FETCH cycle; held in WAIT because memory keeps its response until taken.
    always_comb begin
        imem_rd_en = 1'b0;
        case (state)
            FETCH:   imem_rd_en = enable & ~stall & ~flush;
            WAIT:    imem_rd_en = 1'b1;
            default: imem_rd_en = 1'b0;
        endcase
    end

    // An instruction moves into IF/ID on this edge.
    always_comb begin
        do_load = 1'b0;
        if (enable && !flush && !stall) begin
            case (state)
                FETCH:   do_load = imem_ready;
                WAIT:    do_load = imem_ready & ~drop;
                BUF:     do_load = 1'b1;
                default: do_load = 1'b0;
            endcase
        end
    end

    // Fetch FSM, PC and IF/ID register; flush outranks stall in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            curr_pc_fd    <= 16'h0000;
            curr_instr_fd <= NOP_INSTR;
            fd_valid      <= 1'b0;
            halted        <= 1'b0;
            drop          <= 1'b0;
            buf_instr     <= NOP_INSTR;
        end else if (enable) begin
            if (flush) begin
                curr_instr_fd <= NOP_INSTR;
                fd_valid      <= 1'b0;
                pc            <= redirect_pc;
                buf_instr     <= NOP_INSTR;
                halted        <= 1'b0;
                // A request is still outstanding in WAIT: its response must be swallowed.
                if (state == WAIT) begin
                    drop <= 1'b1;
                end else begin
                    state <= FETCH;
                end
            end else if (do_load) begin
                curr_pc_fd    <= pc;
                curr_instr_fd <= load_instr;
                fd_valid      <= 1'b1;
                if (load_hlt) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    pc    <= pc + 16'd2;
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (!stall) begin
                            state         <= WAIT;
                            curr_instr_fd <= NOP_INSTR;
                            fd_valid      <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (imem_ready) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= FETCH;
                            end else begin
                                buf_instr <= imem_data;
                                state     <= BUF;
                            end
                        end
                    end
                    HALT: begin
                        if (!stall) begin
                            curr_instr_fd <= NOP_INSTR;
                            fd_valid      <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counts of instructions delivered and of live bubble cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count  <= 16'h0000;
            bubble_count <= 16'h0000;
        end else begin
            if (do_load && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (enable && !fd_valid && !halted && bubble_count != 16'hFFFF) begin
                bubble_count <= bubble_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural memory and program-order scoreboard
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'hE000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [15:0] branch_pc;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic [15:0] curr_pc_fd;
    logic [15:0] curr_instr_fd;
    logic        fd_valid;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:255];
    bit          mem_busy;
    int          mem_left;
    logic [15:0] mem_addr;
    int          next_lat;
    bit          req_started;
    logic [15:0] req_addr;
    bit          seen_rd_en;
    int          req_count;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .stall         (stall),
        .flush         (flush),
        .branch_pc     (branch_pc),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .imem_ready    (imem_ready),
        .curr_pc_fd    (curr_pc_fd),
        .curr_instr_fd (curr_instr_fd),
        .fd_valid      (fd_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // One clock cycle: drive inputs, let the memory model respond, clock, retire the response.
    task automatic step(input logic en, input logic st, input logic fl, input logic [15:0] bpc);
        enable    = en;
        stall     = st;
        flush     = fl;
        branch_pc = bpc;
        #1;
        seen_rd_en  = imem_rd_en;
        req_started = 0;
        if (!mem_busy && imem_rd_en) begin
            mem_busy    = 1;
            mem_addr    = imem_addr;
            mem_left    = next_lat;
            req_started = 1;
            req_addr    = imem_addr;
            req_count++;
        end
        imem_ready = mem_busy && (mem_left == 0);
        imem_data  = imem_ready ? mem[mem_addr[8:1]] : 16'($urandom);
        @(posedge clk);
        #1;
        if (imem_ready && en) mem_busy = 0;
        else if (mem_busy && mem_left > 0) mem_left--;
        imem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic adv();
        step(1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        enable     = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        branch_pc  = 16'h0000;
        imem_ready = 1'b0;
        imem_data  = 16'h0000;
        mem_busy   = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        enable     = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        branch_pc  = 16'h0000;
        imem_ready = 1'b0;
        imem_data  = 16'h0000;
        mem_busy   = 0;
        @(negedge clk);
        checks++;
        if (curr_pc_fd !== 16'h0000 || curr_instr_fd !== NOP || fd_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got pc=%h instr=%h v=%b h=%b, want 0000 e000 0 0",
                     curr_pc_fd, curr_instr_fd, fd_valid, halted);
        end
        checks++;
        if (imem_addr !== 16'h0000 || imem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_request: got addr=%h rd=%b, want 0000 1", imem_addr, imem_rd_en);
        end
        rst = 1'b1;
    endtask

    task automatic test_zero_wait();
        next_lat = 0;
        adv();
        checks++;
        if (curr_pc_fd !== 16'h0000 || curr_instr_fd !== 16'h1234 || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_wait_c1: got %h/%h v=%b, want 0000/1234 v=1", curr_pc_fd, curr_instr_fd, fd_valid);
        end
        adv();
        checks++;
        if (curr_pc_fd !== 16'h0002 || curr_instr_fd !== 16'h5678 || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_wait_c2: got %h/%h v=%b, want 0002/5678 v=1", curr_pc_fd, curr_instr_fd, fd_valid);
        end
    endtask

    task automatic test_wait_latency();
        int rc0;
        rc0 = req_count;
        next_lat = 3;
        for (int k = 0; k < 3; k++) begin
            adv();
            checks++;
            if (fd_valid !== 1'b0 || curr_instr_fd !== NOP || (k > 0 && seen_rd_en !== 1'b1)) begin
                errors++;
                $display("FAIL wait_bubble[%0d]: got v=%b instr=%h rd=%b, want v=0 e000 rd=1",
                         k, fd_valid, curr_instr_fd, seen_rd_en);
            end
        end
        adv();
        checks++;
        if (seen_rd_en !== 1'b1 || curr_pc_fd !== 16'h0004 || curr_instr_fd !== mem[2] || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_load: got rd=%b %h/%h v=%b, want rd=1 0004/%h v=1",
                     seen_rd_en, curr_pc_fd, curr_instr_fd, fd_valid, mem[2]);
        end
        checks++;
        if (req_count - rc0 !== 1) begin
            errors++;
            $display("FAIL wait_requests: got %0d requests, want 1", req_count - rc0);
        end
        next_lat = 0;
    endtask

    task automatic test_stall_buf();
        int rc0;
        rc0 = req_count;
        next_lat = 2;
        adv();
        adv();
        next_lat = 0;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0000);
            checks++;
            if (fd_valid !== 1'b0 || curr_instr_fd !== NOP) begin
                errors++;
                $display("FAIL buf_stall[%0d]: got v=%b instr=%h, want v=0 e000", k, fd_valid, curr_instr_fd);
            end
        end
        adv();
        checks++;
        if (seen_rd_en !== 1'b0 || curr_pc_fd !== 16'h0006 || curr_instr_fd !== mem[3] || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL buf_release: got rd=%b %h/%h v=%b, want rd=0 0006/%h v=1",
                     seen_rd_en, curr_pc_fd, curr_instr_fd, fd_valid, mem[3]);
        end
        checks++;
        if (req_count - rc0 !== 1) begin
            errors++;
            $display("FAIL buf_requests: got %0d requests, want 1", req_count - rc0);
        end
    endtask

    task automatic test_stall_hold();
        adv();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0000);
            checks++;
            if (seen_rd_en !== 1'b0 || curr_pc_fd !== 16'h0008 || curr_instr_fd !== mem[4] || fd_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rd=%b %h/%h v=%b, want rd=0 0008/%h v=1",
                         k, seen_rd_en, curr_pc_fd, curr_instr_fd, fd_valid, mem[4]);
            end
        end
        adv();
        checks++;
        if (curr_pc_fd !== 16'h000A || curr_instr_fd !== mem[5] || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got %h/%h v=%b, want 000a/%h v=1", curr_pc_fd, curr_instr_fd, fd_valid, mem[5]);
        end
    endtask

    task automatic test_flush_wait();
        bit got;
        next_lat = 4;
        adv();
        next_lat = 0;
        step(1'b1, 1'b0, 1'b1, 16'h0041);
        checks++;
        if (fd_valid !== 1'b0 || curr_instr_fd !== NOP || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL flush_wait: got v=%b instr=%h addr=%h, want v=0 e000 0040", fd_valid, curr_instr_fd, imem_addr);
        end
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            adv();
            if (fd_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got || curr_pc_fd !== 16'h0040 || curr_instr_fd !== mem[8'h20] || req_addr !== 16'h0040) begin
            errors++;
            $display("FAIL flush_redirect: got loaded=%0d %h/%h req=%h, want 1 0040/%h req=0040",
                     got, curr_pc_fd, curr_instr_fd, req_addr, mem[8'h20]);
        end
    endtask

    task automatic test_halt();
        step(1'b1, 1'b0, 1'b1, 16'h0010);
        adv();
        checks++;
        if (curr_pc_fd !== 16'h0010 || curr_instr_fd !== 16'hF000 || fd_valid !== 1'b1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_load: got %h/%h v=%b h=%b, want 0010/f000 v=1 h=1", curr_pc_fd, curr_instr_fd, fd_valid, halted);
        end
        adv();
        adv();
        checks++;
        if (halted !== 1'b1 || fd_valid !== 1'b0 || curr_instr_fd !== NOP || seen_rd_en !== 1'b0 || imem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL halt_idle: got h=%b v=%b instr=%h rd=%b addr=%h, want 1 0 e000 0 0010",
                     halted, fd_valid, curr_instr_fd, seen_rd_en, imem_addr);
        end
        step(1'b1, 1'b0, 1'b1, 16'h0020);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_flush: got halted=%b, want 0", halted);
        end
        adv();
        checks++;
        if (curr_pc_fd !== 16'h0020 || curr_instr_fd !== mem[8'h10] || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_resume: got %h/%h v=%b, want 0020/%h v=1", curr_pc_fd, curr_instr_fd, fd_valid, mem[8'h10]);
        end
    endtask

    task automatic test_async_reset();
        next_lat = 5;
        adv();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (curr_pc_fd !== 16'h0000 || curr_instr_fd !== NOP || fd_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %h/%h v=%b h=%b addr=%h, want 0000/e000 0 0 0000",
                     curr_pc_fd, curr_instr_fd, fd_valid, halted, imem_addr);
        end
        mem_busy   = 0;
        imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        next_lat = 0;
        adv();
        checks++;
        if (req_addr !== 16'h0000 || curr_pc_fd !== 16'h0000 || curr_instr_fd !== 16'h1234 || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: got req=%h %h/%h v=%b, want 0000 0000/1234 v=1",
                     req_addr, curr_pc_fd, curr_instr_fd, fd_valid);
        end
    endtask

    task automatic test_enable_freeze();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (seen_rd_en !== 1'b0 || curr_pc_fd !== 16'h0000 || curr_instr_fd !== 16'h1234 || fd_valid !== 1'b1) begin
                errors++;
                $display("FAIL freeze_fetch[%0d]: got rd=%b %h/%h v=%b, want 0 0000/1234 1",
                         k, seen_rd_en, curr_pc_fd, curr_instr_fd, fd_valid);
            end
        end
        next_lat = 2;
        adv();
        next_lat = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (seen_rd_en !== 1'b1 || fd_valid !== 1'b0) begin
                errors++;
                $display("FAIL freeze_wait[%0d]: got rd=%b v=%b, want rd=1 v=0", k, seen_rd_en, fd_valid);
            end
        end
        adv();
        checks++;
        if (curr_pc_fd !== 16'h0002 || curr_instr_fd !== 16'h5678 || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_release: got %h/%h v=%b, want 0002/5678 v=1", curr_pc_fd, curr_instr_fd, fd_valid);
        end
    endtask

    task automatic test_pc_wrap();
        step(1'b1, 1'b0, 1'b1, 16'hFFFE);
        adv();
        checks++;
        if (curr_pc_fd !== 16'hFFFE || curr_instr_fd !== mem[8'hFF] || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_top: got %h/%h v=%b, want fffe/%h v=1", curr_pc_fd, curr_instr_fd, fd_valid, mem[8'hFF]);
        end
        adv();
        checks++;
        if (curr_pc_fd !== 16'h0000 || curr_instr_fd !== 16'h1234 || fd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero: got %h/%h v=%b, want 0000/1234 v=1", curr_pc_fd, curr_instr_fd, fd_valid);
        end
    endtask

    // Program-order reference: loads must follow exp_pc, redirected by flush, stopped by HLT.
    task automatic test_random();
        logic [15:0] exp_pc;
        bit          exp_halt;
        int          loads;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        do_reset();
        exp_pc   = 16'h0000;
        exp_halt = 0;
        loads    = 0;
        for (int i = 0; i < 1500; i++) begin
            logic        en;
            logic        st;
            logic        fl;
            logic [15:0] bpc;
            logic [15:0] p_pc;
            logic [15:0] p_instr;
            logic [15:0] word;
            logic        p_v;
            logic        p_h;
            en       = ($urandom_range(0, 9) != 0);
            st       = ($urandom_range(0, 4) == 0);
            fl       = ($urandom_range(0, 11) == 0);
            bpc      = 16'($urandom_range(0, 511));
            next_lat = $urandom_range(0, 3);
            p_pc     = curr_pc_fd;
            p_instr  = curr_instr_fd;
            p_v      = fd_valid;
            p_h      = halted;
            step(en, st, fl, bpc);
            if (req_started) begin
                checks++;
                if (req_addr !== exp_pc || exp_halt) begin
                    errors++;
                    $display("FAIL rand_request[%0d]: got addr=%h halted_model=%0d, want addr=%h", i, req_addr, exp_halt, exp_pc);
                end
            end
            if (!en) begin
                checks++;
                if (curr_pc_fd !== p_pc || curr_instr_fd !== p_instr || fd_valid !== p_v || halted !== p_h) begin
                    errors++;
                    $display("FAIL rand_freeze[%0d]: got %h/%h v=%b h=%b, want %h/%h v=%b h=%b",
                             i, curr_pc_fd, curr_instr_fd, fd_valid, halted, p_pc, p_instr, p_v, p_h);
                end
            end else if (fl) begin
                exp_pc   = bpc & 16'hFFFE;
                exp_halt = 0;
                checks++;
                if (fd_valid !== 1'b0 || curr_instr_fd !== NOP || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_flush[%0d]: got v=%b instr=%h h=%b, want 0 e000 0", i, fd_valid, curr_instr_fd, halted);
                end
            end else if (st) begin
                checks++;
                if (curr_pc_fd !== p_pc || curr_instr_fd !== p_instr || fd_valid !== p_v || halted !== p_h) begin
                    errors++;
                    $display("FAIL rand_stall[%0d]: got %h/%h v=%b h=%b, want %h/%h v=%b h=%b",
                             i, curr_pc_fd, curr_instr_fd, fd_valid, halted, p_pc, p_instr, p_v, p_h);
                end
            end else if (fd_valid === 1'b1) begin
                word = mem[exp_pc[8:1]];
                checks++;
                if (exp_halt || curr_pc_fd !== exp_pc || curr_instr_fd !== word) begin
                    errors++;
                    $display("FAIL rand_load[%0d]: got %h/%h halted_model=%0d, want %h/%h",
                             i, curr_pc_fd, curr_instr_fd, exp_halt, exp_pc, word);
                end
                loads++;
                if (word[15:12] == 4'hF) exp_halt = 1;
                else exp_pc = exp_pc + 16'd2;
                checks++;
                if (halted !== exp_halt) begin
                    errors++;
                    $display("FAIL rand_halted[%0d]: got %b, want %0d", i, halted, exp_halt);
                end
            end else begin
                checks++;
                if (curr_instr_fd !== NOP || halted !== exp_halt) begin
                    errors++;
                    $display("FAIL rand_bubble[%0d]: got instr=%h h=%b, want e000 h=%0d", i, curr_instr_fd, halted, exp_halt);
                end
            end
        end
        checks++;
        if (loads < 100) begin
            errors++;
            $display("FAIL rand_progress: got %0d loads, want at least 100", loads);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) & 16'h7FFF;
        mem[0]     = 16'h1234;
        mem[1]     = 16'h5678;
        mem[8]     = 16'hF000;
        mem_busy   = 0;
        next_lat   = 0;
        req_count  = 0;
        req_addr   = 16'h0000;
        imem_ready = 1'b0;
        imem_data  = 16'h0000;
        rst        = 1'b0;
        enable     = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        branch_pc  = 16'h0000;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_latency();
        test_stall_buf();
        test_stall_hold();
        test_flush_wait();
        test_halt();
        test_async_reset();
        test_enable_freeze();
        test_pc_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register: the producer side of the fetch/decode interface.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Drives curr_pc_fd/curr_instr_fd into decode.
- Obeys decode's stall (hold) and flush (branch redirect to branch_pc), and stops fetching after an HLT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hE000, bubble instruction (PCS $0) placed in IF/ID.
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  global advance enable; low freezes all state.
- stall  input  1  decode hazard hold; IF/ID and PC are held.
- flush  input  1  branch taken in decode; redirect and squash.
- branch_pc  input  16  redirect target, valid when flush=1.
- imem_rd_en  output  1  instruction memory request.
- imem_addr  output  16  request address.
- imem_data  input  16  returned instruction, valid when imem_ready=1.
- imem_ready  input  1  response valid this cycle; may be asserted in the same cycle as the request.
- curr_pc_fd  output  16  address of the instruction in IF/ID.
- curr_instr_fd  output  16  instruction in IF/ID.
- fd_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch stopped on HLT.

Behaviour:
- Reset (async, rst=0): pc=RESET_PC, curr_pc_fd=0, curr_instr_fd=NOP_INSTR, fd_valid=0, halted=0, drop=0, state=FETCH.
- All register updates are gated by enable. With enable=0, imem_rd_en=0 in FETCH and held at 1 in WAIT, because the memory holds its response until consumed.
- States: FETCH, WAIT, BUF, HALT. imem_addr=pc always.
- FETCH: imem_rd_en = enable & ~stall & ~flush.
  - imem_ready=1: on the edge, IF/ID <= {pc, imem_data}, fd_valid=1, pc <= pc+2.
  - If imem_data[15:12]==HLT_OPCODE, go to HALT with pc not advanced.
  - imem_ready=0: go to WAIT; IF/ID <= NOP_INSTR, fd_valid=0.
- WAIT: imem_rd_en=1, IF/ID holds the bubble.
  - On imem_ready with ~stall: load as in FETCH, go to FETCH (or HALT).
  - On imem_ready with stall: capture the instruction and pc into a one-entry buffer, go to BUF.
- BUF: imem_rd_en=0. When stall drops, the buffered entry loads IF/ID, pc <= pc+2, and the state goes to FETCH (or HALT).
- stall (no flush): IF/ID, pc and fd_valid hold their values. No new request is issued from FETCH.
- flush (highest priority, overrides stall, any state):
  - IF/ID <= NOP_INSTR, fd_valid=0, pc <= branch_pc, buffer cleared, halted=0.
  - From FETCH/BUF/HALT: go to FETCH.
  - From WAIT: set drop=1 and stay in WAIT. The next imem_ready response is discarded, then drop clears and the state goes to FETCH at branch_pc.
  - A flush arriving while drop=1 updates pc only.
- HALT: halted=1, imem_rd_en=0, IF/ID receives NOP_INSTR/fd_valid=0 after the HLT advances (~stall). Only flush or reset exits HALT.
- PC arithmetic: 16-bit wrap, 16'hFFFE+2 = 16'h0000. branch_pc[0] is ignored and treated as 0.
- Latency: with a zero-wait memory, an instruction is in IF/ID one cycle after its request; one instruction per cycle.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_count[15:0] (instructions loaded into IF/ID with fd_valid=1) and bubble_count[15:0] (cycles with fd_valid=0 while enable=1 and not halted).
  - Both counters saturate at 16'hFFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: no such ports and no counter logic.

Test Plan:
- Zero-wait memory returning 16'h1234 at 0x0000 and 16'h5678 at 0x0002 → cycle 1 curr_pc_fd=0x0000/instr=0x1234, cycle 2 0x0002/0x5678, fd_valid=1 both.
- imem_ready delayed 3 cycles for address 0x0004 → fd_valid=0 and instr=16'hE000 for 3 cycles, then 0x0004 loads; imem_rd_en held at 1 throughout WAIT.
- stall for 2 cycles while a WAIT response arrives → IF/ID unchanged during stall, state BUF; the buffered instruction appears on the cycle after stall drops; no duplicate request.
- flush with branch_pc=0x0040 while in WAIT → in-flight response dropped, next request address is 0x0040, IF/ID=16'hE000, fd_valid=0.
- HLT (16'hF000) fetched at 0x0010 → halted=1, pc stays 0x0010, imem_rd_en=0. A subsequent flush to 0x0020 clears halted and fetch resumes at 0x0020.
- Async reset (rst=0) mid-WAIT → outputs immediately at reset values; first request after release is to RESET_PC.
